// File: rtl/mesi_bus_mem_responder.sv
// Shared-bus memory responder for the 4-core MESI bus: proc/snoop arbitration, memory fills and write-backs.
// Optional bus-ownership watchdog enabled by defining BUS_TIMEOUT_EN.
module mesi_bus_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LAT     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        Com_Bus_Req_proc,
  output logic [3:0]        Com_Bus_Gnt_proc,
  input  logic [3:0]        Com_Bus_Req_snoop,
  output logic [3:0]        Com_Bus_Gnt_snoop,
  input  logic [ADDR_W-1:0] Address_Com,
  inout  wire  [ADDR_W-1:0] Data_Bus_Com,
  input  logic              BusRd,
  input  logic              BusRdX,
  input  logic              Invalidate,
  inout  wire               Data_in_Bus,
  input  logic              Mem_wr,
  input  logic              Mem_oprn_abort,
  output logic              Mem_write_done,
  input  logic [3:0]        Invalidation_done,
  output logic              All_Invalidation_done,
  input  logic [3:0]        Shared_local,
  output logic              Shared
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_OWNED, S_RD_WAIT, S_RD_DRIVE, S_WR_WAIT, S_WR_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_gnt_proc, r_gnt_snoop;
  logic [1:0]        r_ptr;
  logic [AW-1:0]     r_addr;
  logic [ADDR_W-1:0] r_wdata, r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_all_inv;
  logic [ADDR_W-1:0] r_mem [MEM_WORDS];

  logic       w_owner_req, w_snoop_wr, w_cnt_done, w_to_hit;
  logic       w_rr_hit;
  logic [1:0] w_rr_idx, w_rr_cand;
  logic       w_grant, w_revoke, w_lat_wr, w_lat_rd, w_mem_we, w_rd_load;
  logic       w_drive;
  logic       w_addr_unused;

  assign w_addr_unused = ^Address_Com[ADDR_W-1:AW];
  assign w_owner_req   = |(Com_Bus_Req_proc & r_gnt_proc);
  assign w_snoop_wr    = Mem_wr && (|r_gnt_snoop);
  assign w_cnt_done    = (r_cnt == LAT_C);

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts consecutive OWNED cycles; any state change restarts it.
  always_ff @(posedge clk) begin
    if (rst)
      r_to_cnt <= '0;
    else if (r_state == S_OWNED && w_state_nxt == S_OWNED && r_to_cnt != TO_LAST)
      r_to_cnt <= r_to_cnt + 1'b1;
    else if (!(r_state == S_OWNED && w_state_nxt == S_OWNED))
      r_to_cnt <= '0;
  end

  assign w_to_hit = (r_to_cnt == TO_LAST);
`else
  assign w_to_hit = 1'b0;
`endif

  // Round-robin search starting at r_ptr; the smallest offset with a request wins.
  always_comb begin
    w_rr_hit  = 1'b0;
    w_rr_idx  = r_ptr;
    w_rr_cand = '0;
    for (int k = 3; k >= 0; k--) begin
      w_rr_cand = r_ptr + 2'(k);
      if (Com_Bus_Req_proc[w_rr_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_rr_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_revoke    = 1'b0;
    w_lat_wr    = 1'b0;
    w_lat_rd    = 1'b0;
    w_mem_we    = 1'b0;
    w_rd_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_snoop_wr) begin
          w_lat_wr    = 1'b1;
          w_state_nxt = S_WR_WAIT;
        end else if (w_rr_hit) begin
          w_grant     = 1'b1;
          w_state_nxt = S_OWNED;
        end
      end
      S_OWNED: begin
        if (!w_owner_req) begin
          w_revoke    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (Mem_wr) begin
          w_lat_wr    = 1'b1;
          w_state_nxt = S_WR_WAIT;
        end else if ((BusRd || BusRdX) && !Invalidate) begin
          w_lat_rd    = 1'b1;
          w_state_nxt = S_RD_WAIT;
        end else if (w_to_hit) begin
          w_revoke    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        // Abort beats expiry so a cache-supplied line is never double-driven.
        if (Mem_oprn_abort)
          w_state_nxt = S_OWNED;
        else if (w_cnt_done) begin
          w_rd_load   = 1'b1;
          w_state_nxt = S_RD_DRIVE;
        end
      end
      S_RD_DRIVE: begin
        if (!BusRd && !BusRdX)
          w_state_nxt = S_OWNED;
      end
      S_WR_WAIT: begin
        if (w_cnt_done) begin
          w_mem_we    = 1'b1;
          w_state_nxt = S_WR_DONE;
        end
      end
      S_WR_DONE: begin
        if (!Mem_wr)
          w_state_nxt = S_OWNED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt_proc <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != w_state_nxt)
        r_cnt <= '0;
      else if (!w_cnt_done)
        r_cnt <= r_cnt + 1'b1;
      if (w_grant) begin
        r_gnt_proc <= 4'b0001 << w_rr_idx;
        r_ptr      <= w_rr_idx + 2'd1;
      end else if (w_revoke) begin
        r_gnt_proc <= '0;
      end
      if (w_lat_wr) begin
        r_addr  <= Address_Com[AW-1:0];
        r_wdata <= Data_Bus_Com;
      end else if (w_lat_rd) begin
        r_addr  <= Address_Com[AW-1:0];
      end
      if (w_rd_load)
        r_rdata <= r_mem[r_addr];
    end
  end

  // Memory array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we)
      r_mem[r_addr] <= r_wdata;
  end

  // Snoop grant: lowest-index requester, held until its request drops.
  always_ff @(posedge clk) begin
    if (rst)
      r_gnt_snoop <= '0;
    else if (|r_gnt_snoop) begin
      if (!(|(Com_Bus_Req_snoop & r_gnt_snoop)))
        r_gnt_snoop <= '0;
    end else
      r_gnt_snoop <= Com_Bus_Req_snoop & (~Com_Bus_Req_snoop + 4'd1);
  end

  // The owner never acknowledges its own invalidate, so its bit is masked in.
  always_ff @(posedge clk) begin
    if (rst)
      r_all_inv <= 1'b0;
    else
      r_all_inv <= Invalidate && (&(Invalidation_done | r_gnt_proc));
  end

  assign w_drive               = (r_state == S_RD_DRIVE);
  assign Data_Bus_Com          = w_drive ? r_rdata : {ADDR_W{1'bz}};
  assign Data_in_Bus           = w_drive ? 1'b1 : 1'bz;
  assign Com_Bus_Gnt_proc      = r_gnt_proc;
  assign Com_Bus_Gnt_snoop     = r_gnt_snoop;
  assign Mem_write_done        = (r_state == S_WR_DONE);
  assign All_Invalidation_done = r_all_inv;
  assign Shared                = |Shared_local;

endmodule
